// File: rtl/axis_snooper_if.sv
// axis_snooper_if: AXI-Stream signal bundle for the observed packet bus.
//   TDATA  - stream data
//   TKEEP  - byte enables, contiguous from bit 0
//   TVALID - source valid
//   TREADY - sink ready (observed only, the snooper never drives it)
//   TLAST  - end of packet
// master drives the whole bundle (the stream model); slave only observes.
interface axis_snooper_if #(
   parameter int DATA_WIDTH = 64
) ();
   logic [DATA_WIDTH-1:0]   TDATA;
   logic [DATA_WIDTH/8-1:0] TKEEP;
   logic                    TVALID;
   logic                    TREADY;
   logic                    TLAST;

   modport master (output TDATA, TKEEP, TVALID, TREADY, TLAST);
   modport slave  (input  TDATA, TKEEP, TVALID, TREADY, TLAST);
endinterface

// File: rtl/axis_snooper.sv
// axis_snooper: passive tap on an AXI-Stream bus. Every accepted flit of a
// packet that starts while a core is ready becomes a packet-memory write.
// Packets starting while no core is ready are dropped; packets longer than
// packet memory are truncated. Both cases are counted (saturating).
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   snoop       - observed stream (slave modport, inputs only)
//   rdy         - arbiter has a core ready; sampled on a packet's first beat
//   addr        - word address of the current/last write
//   wr_data     - write data
//   wr_en       - write strobe
//   byte_inc    - valid bytes in this write (popcount of TKEEP)
//   done        - one-cycle end-of-packet pulse
//   drop_cnt    - whole packets dropped
//   trunc_cnt   - packets truncated by overflow
module axis_snooper #(
   parameter int SN_ADDR_WIDTH = 8,
   parameter int DATA_WIDTH    = 64,
   parameter int INC_WIDTH     = 8,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   axis_snooper_if.slave            snoop,
   input  logic                     rdy,
   output logic [SN_ADDR_WIDTH-1:0] addr,
   output logic [DATA_WIDTH-1:0]    wr_data,
   output logic                     wr_en,
   output logic [INC_WIDTH-1:0]     byte_inc,
   output logic                     done,
   output logic [CNT_WIDTH-1:0]     drop_cnt,
   output logic [CNT_WIDTH-1:0]     trunc_cnt
);
   typedef enum logic [1:0] {IDLE, CAPTURE, FULL, DROP} state_t;

   state_t                   state;
   // Set when a packet has started but nothing was written yet (TKEEP=0
   // start beat), so the first real write still lands at address 0.
   logic                     first_pend;
   logic                     beat;
   logic                     has_data;
   logic [INC_WIDTH-1:0]     keep_cnt;
   logic [SN_ADDR_WIDTH-1:0] next_addr;

   assign beat      = snoop.TVALID & snoop.TREADY;
   assign has_data  = |snoop.TKEEP;
   assign next_addr = first_pend ? '0 : addr + SN_ADDR_WIDTH'(1);

   always_comb begin
      keep_cnt = '0;
      for (int i = 0; i < DATA_WIDTH/8; i++)
         keep_cnt = keep_cnt + INC_WIDTH'(snoop.TKEEP[i]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         first_pend <= 1'b0;
         addr       <= '0;
         wr_data    <= '0;
         wr_en      <= 1'b0;
         byte_inc   <= '0;
         done       <= 1'b0;
         drop_cnt   <= '0;
         trunc_cnt  <= '0;
      end else begin
         // strobes are single-cycle; data/addr hold between beats
         wr_en <= 1'b0;
         done  <= 1'b0;
         if (beat) begin
            case (state)
               IDLE: begin
                  if (rdy) begin
                     wr_data    <= snoop.TDATA;
                     byte_inc   <= keep_cnt;
                     wr_en      <= has_data;
                     addr       <= '0;
                     first_pend <= ~has_data;
                     done       <= snoop.TLAST;
                     if (!snoop.TLAST) state <= CAPTURE;
                  end else begin
                     if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_WIDTH'(1);
                     if (!snoop.TLAST) state <= DROP;
                  end
               end
               CAPTURE: begin
                  wr_data  <= snoop.TDATA;
                  byte_inc <= keep_cnt;
                  wr_en    <= has_data;
                  done     <= snoop.TLAST;
                  if (has_data) begin
                     addr       <= next_addr;
                     first_pend <= 1'b0;
                  end
                  if (snoop.TLAST)
                     state <= IDLE;
                  else if (has_data && next_addr == '1)
                     state <= FULL;   // memory exhausted, rest is discarded
               end
               FULL: begin
                  if (snoop.TLAST) begin
                     done  <= 1'b1;
                     if (trunc_cnt != '1) trunc_cnt <= trunc_cnt + CNT_WIDTH'(1);
                     state <= IDLE;
                  end
               end
               DROP: begin
                  if (snoop.TLAST) state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule
